// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the operation encoding, the FSM state encoding and the ALU
// control codes used by both muldiv_seq and alu.
// No ports (package).

package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/alu.sv
// Team ALU: purely combinational two-operand arithmetic/logic unit.
// Ports:
//   ctrl_i  4-bit operation select (ALU_* codes from muldiv_pkg)
//   a_i     first operand
//   b_i     second operand
//   y_o     result, same width as the operands (carry/borrow not exported)

module alu
    import muldiv_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [3:0]           ctrl_i,
    input  logic [REG_WIDTH-1:0] a_i,
    input  logic [REG_WIDTH-1:0] b_i,
    output logic [REG_WIDTH-1:0] y_o
);

    // Select the operation; anything unrecognised falls back to add so
    // the output is never undefined.
    always_comb begin
        y_o = a_i + b_i;
        case (ctrl_i)
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            default: y_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit, one bit per clock.
// MUL/MULHU use shift-add, DIVU/REMU use restoring division; both share a
// single ALU instance. Division is only built when macro MULDIV_DIV_EN is
// defined; otherwise DIVU/REMU complete in one cycle returning 0.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   req_valid/req_ready    request handshake (op, in1, in2 latched on accept)
//   op                     00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   in1, in2               multiplicand/dividend, multiplier/divisor
//   resp_valid/resp_ready  response handshake, result held until taken
//   result                 operation result
//   busy                   high whenever the FSM is not idle

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           op,
    input  logic [REG_WIDTH-1:0] in1,
    input  logic [REG_WIDTH-1:0] in2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic                 busy
);

    localparam int CNT_W = (REG_WIDTH > 2) ? $clog2(REG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REG_WIDTH - 1);

    state_e               state_q;
    op_e                  op_q;
    logic [CNT_W-1:0]     count_q;
    logic [REG_WIDTH-1:0] operand_q;
    logic [REG_WIDTH-1:0] hiWord_q;
    logic [REG_WIDTH-1:0] loWord_q;
    logic [REG_WIDTH-1:0] result_q;
    logic                 respValid_q;
    logic                 busy_q;

    logic [REG_WIDTH-1:0] hiWord_d;
    logic [REG_WIDTH-1:0] loWord_d;
    logic [3:0]           aluCtrl;
    logic [REG_WIDTH-1:0] aluA;
    logic [REG_WIDTH-1:0] aluY;
    logic [REG_WIDTH-1:0] mulSum;
    logic                 mulCarry;
    logic                 isMul;

    assign isMul = ~op_q[1];

`ifdef MULDIV_DIV_EN
    logic [REG_WIDTH:0] shiftedRem;
    logic               noBorrow;

    // The partial remainder shifted left with the next dividend bit needs
    // one extra bit; the wide compare tells us whether the trial subtract
    // would borrow, so the ALU only has to produce the low word.
    assign shiftedRem = {hiWord_q, loWord_q[REG_WIDTH-1]};
    assign noBorrow   = shiftedRem >= {1'b0, operand_q};
`endif

    // Steer the shared ALU: multiply accumulates into the high word,
    // divide subtracts the divisor from the shifted remainder.
    always_comb begin
        aluCtrl = ALU_ADD;
        aluA    = hiWord_q;
`ifdef MULDIV_DIV_EN
        if (!isMul) begin
            aluCtrl = ALU_SUB;
            aluA    = shiftedRem[REG_WIDTH-1:0];
        end
`endif
    end

    alu #(
        .REG_WIDTH(REG_WIDTH)
    ) u_alu (
        .ctrl_i(aluCtrl),
        .a_i   (aluA),
        .b_i   (operand_q),
        .y_o   (aluY)
    );

    // One iteration of the datapath. For multiply the add carry is
    // recovered by noticing the sum wrapped below the old high word, and
    // {carry,hi,lo} shifts right so the product settles into hi:lo.
    // For divide {rem,quot} shifts left and the quotient bit is the
    // inverse of the borrow.
    always_comb begin
        mulCarry = loWord_q[0] && ({1'b0, aluY} < {1'b0, hiWord_q});
        mulSum   = loWord_q[0] ? aluY : hiWord_q;
        hiWord_d = {mulCarry, mulSum[REG_WIDTH-1:1]};
        loWord_d = {mulSum[0], loWord_q[REG_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (!isMul) begin
            hiWord_d = noBorrow ? aluY : shiftedRem[REG_WIDTH-1:0];
            loWord_d = {loWord_q[REG_WIDTH-2:0], noBorrow};
        end
`endif
    end

    // Control FSM and all registered state. Accepting a request loads the
    // operands and the iteration counter; the last CALC cycle captures the
    // low word (MUL, DIVU) or high word (MULHU, REMU) as the result, which
    // is then held in DONE until the consumer takes it. Division by zero
    // and, in builds without division, any divide op skip CALC entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            count_q     <= '0;
            operand_q   <= '0;
            hiWord_q    <= '0;
            loWord_q    <= '0;
            result_q    <= '0;
            respValid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_e'(op);
                        count_q <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        if (!op[1]) begin
                            operand_q <= in1;
                            hiWord_q  <= '0;
                            loWord_q  <= in2;
                            state_q   <= S_CALC;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (in2 == '0) begin
                                result_q    <= op[0] ? in1 : '1;
                                respValid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                operand_q <= in2;
                                hiWord_q  <= '0;
                                loWord_q  <= in1;
                                state_q   <= S_CALC;
                            end
`else
                            result_q    <= '0;
                            respValid_q <= 1'b1;
                            state_q     <= S_DONE;
`endif
                        end
                    end
                end
                S_CALC: begin
                    hiWord_q <= hiWord_d;
                    loWord_q <= loWord_d;
                    if (count_q == '0) begin
                        result_q    <= op_q[0] ? hiWord_d : loWord_d;
                        respValid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        respValid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = respValid_q;
    assign result     = result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (REG_WIDTH=32).
// Expected results come from plain 64-bit arithmetic; each accepted
// request pushes its expectation into a queue that a monitor drains
// whenever the DUT hands back a response.

module tb_muldiv_seq;

    localparam int W       = 32;
    localparam int TIMEOUT = 300;

    typedef struct {
        logic [W-1:0] value;
        int           acceptCycle;
        int           latency;
    } expect_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] result;
    logic         busy;

    expect_t expQ[$];
    int      checks      = 0;
    int      failures    = 0;
    int      cycleCount  = 0;
    bit      holdReady   = 1'b0;
    bit      forcedReady = 1'b1;
    bit      monSeen     = 1'b0;

    muldiv_seq #(
        .REG_WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .result    (result),
        .busy      (busy)
    );

    // Free-running clock and a cycle counter used to measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic expect_t modelOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        expect_t      e;
        logic [63:0]  prod;
        prod          = {32'b0, a} * {32'b0, b};
        e.acceptCycle = acc;
        e.latency     = W + 1;
        case (o)
            2'b00: e.value = prod[31:0];
            2'b01: e.value = prod[63:32];
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                    e.value   = (o == 2'b11) ? a : '1;
                    e.latency = 1;
                end else begin
                    e.value = (o == 2'b10) ? a / b : a % b;
                end
`else
                e.value   = '0;
                e.latency = 1;
`endif
            end
        endcase
        return e;
    endfunction

    // Issue one request once the DUT is ready and queue its expectation;
    // inputs are scrambled right after acceptance to show they are ignored.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            reportTimeout("req_ready wait");
            return;
        end
        op        = o;
        in1       = a;
        in2       = b;
        req_valid = 1'b1;
        expQ.push_back(modelOp(o, a, b, cycleCount + 1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op        = 2'($urandom);
        in1       = W'($urandom);
        in2       = W'($urandom);
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (expQ.size() != 0 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (expQ.size() != 0) begin
            reportTimeout("response drain");
            expQ.delete();
        end
    endtask

    function automatic logic [W-1:0] pickOperand(input bit zeroBias);
        int sel = $urandom_range(0, 7);
        if (sel == 0 || (zeroBias && sel == 1)) return '0;
        if (sel == 2) return '1;
        if (sel == 3) return W'($urandom_range(0, 15));
        return W'($urandom);
    endfunction

    // Consumer readiness: random unless a directed test pins it.
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = holdReady ? forcedReady : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks latency on first sight of each response and the
    // result on its handshake; any response with nothing queued is an error.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                monSeen = 1'b0;
            end else if (resp_valid) begin
                if (expQ.size() == 0) begin
                    if (!monSeen) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected response: got 0x%0h, expected none", result);
                    end
                    monSeen = !resp_ready;
                end else begin
                    if (!monSeen) begin
                        checkOutput("latency", 64'(cycleCount - expQ[0].acceptCycle + 1), 64'(expQ[0].latency));
                        monSeen = 1'b1;
                    end
                    if (resp_ready) begin
                        checkOutput("result", 64'(result), 64'(expQ[0].value));
                        void'(expQ.pop_front());
                        monSeen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expect_t      bpExp;
        logic [1:0]   rOp;
        logic [W-1:0] rA;
        logic [W-1:0] rB;
        int           waited;

        reset     = 1'b1;
        req_valid = 1'b0;
        op        = '0;
        in1       = '0;
        in2       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("req_ready after reset", 64'(req_ready), 64'd1);

        $display("[TB] directed operations");
        applyStimulus(2'b00, 32'd7, 32'd6);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 32'd100, 32'd7);
        applyStimulus(2'b11, 32'd100, 32'd7);
        applyStimulus(2'b10, 32'd5, 32'd0);
        applyStimulus(2'b11, 32'd5, 32'd0);
        waitDrain();

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = pickOperand(1'b0);
            rB  = pickOperand(1'b1);
            applyStimulus(rOp, rA, rB);
        end
        waitDrain();

        $display("[TB] backpressure");
        holdReady   = 1'b1;
        forcedReady = 1'b0;
        @(negedge clk);
        bpExp = modelOp(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        applyStimulus(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        waited = 0;
        while (!resp_valid && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!resp_valid) reportTimeout("backpressure resp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("held resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("held result", 64'(result), 64'(bpExp.value));
            checkOutput("held req_ready", 64'(req_ready), 64'd0);
        end
        forcedReady = 1'b1;
        waited = 0;
        while (!(resp_valid && resp_ready) && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!(resp_valid && resp_ready)) reportTimeout("backpressure handshake");
        @(negedge clk);
        checkOutput("req_ready after handshake", 64'(req_ready), 64'd1);
        checkOutput("resp_valid after handshake", 64'(resp_valid), 64'd0);
        waitDrain();

        $display("[TB] reset during calculation");
        applyStimulus(2'b00, W'($urandom), W'($urandom));
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("abort result", 64'(result), 64'd0);
        checkOutput("abort req_ready", 64'(req_ready), 64'd1);
        repeat (40) @(negedge clk);
        holdReady = 1'b0;

        applyStimulus(2'b10, 32'd100, 32'd7);
        applyStimulus(2'b01, 32'h8000_0000, 32'd4);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
